// File: rtl/window_pkg.sv
// Shared types and sizing for the Hanning-window frame sequencer.
// Sizing is derived per instance from FRAME_LEN through buf_depth_for().
package window_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        WAIT_RDY = 2'd1,
        STREAM   = 2'd2,
        RETIRE   = 2'd3
    } win_seq_state_t;

    localparam int DEFAULT_FRAME_LEN = 4096;
    localparam int BUF_DEPTH         = 2 * DEFAULT_FRAME_LEN;
    localparam int PTR_W             = $clog2(BUF_DEPTH);

    // The circular buffer holds two frames so the next hop can land while one replays.
    function automatic int buf_depth_for(input int frame_len);
        return 2 * frame_len;
    endfunction

endpackage

// File: rtl/window_frame_sequencer_if.sv
// Sample-in / window-out bus of the frame sequencer.
// Handshake: audio_valid_in is a one-cycle strobe with no backpressure, and win_valid_out has no ready.
interface window_frame_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 4096
);
    logic signed [DATA_WIDTH-1:0]      audio_sample_in;
    logic                              audio_valid_in;
    logic                              frame_ready_in;
    logic        [$clog2(FRAME_LEN)-1:0] coeff_addr_out;
    logic signed [DATA_WIDTH-1:0]      sample_out;
    logic                              win_valid_out;
    logic                              win_last_out;

    modport master (
        input  audio_sample_in, audio_valid_in, frame_ready_in,
        output coeff_addr_out, sample_out, win_valid_out, win_last_out
    );

    modport slave (
        output audio_sample_in, audio_valid_in, frame_ready_in,
        input  coeff_addr_out, sample_out, win_valid_out, win_last_out
    );
endinterface

// File: rtl/frame_sample_buffer.sv
// Simple dual-port sample RAM: one write port, one read port with RD_LATENCY output registers.
// The array itself is not reset; only the read pipeline is, so sample_out reads 0 after reset.
module frame_sample_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int RD_LATENCY = 2,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem     [DEPTH];
    logic [DATA_WIDTH-1:0] rd_pipe [RD_LATENCY];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                rd_pipe[k] <= '0;
            end
        end else begin
            if (rd_en) begin
                rd_pipe[0] <= mem[rd_addr];
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                rd_pipe[k] <= rd_pipe[k-1];
            end
        end
    end

    assign rd_data = rd_pipe[RD_LATENCY-1];
endmodule

// File: rtl/window_frame_sequencer.sv
// Frame controller for the Hanning-window stage: buffers audio in a circular RAM and replays
// overlapping frames one sample per clock, with the coefficient ROM address issued in lock-step.
module window_frame_sequencer
    import window_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
    parameter int HOP        = DEFAULT_FRAME_LEN / 2,
    parameter int RD_LATENCY = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    window_frame_sequencer_if.master bus,
    output logic                     busy_out,
    output logic [15:0]              frame_count_out,
    output logic                     overrun_out,
    output win_seq_state_t           state_dbg_out
);
    localparam int BUF_LEN  = buf_depth_for(FRAME_LEN);
    localparam int PTR_BITS = $clog2(BUF_LEN);
    localparam int IDX_BITS = $clog2(FRAME_LEN);

    localparam logic [PTR_BITS:0]   BUF_FULL  = (PTR_BITS+1)'(BUF_LEN);
    localparam logic [PTR_BITS:0]   FRAME_CNT = (PTR_BITS+1)'(FRAME_LEN);
    localparam logic [PTR_BITS:0]   HOP_CNT   = (PTR_BITS+1)'(HOP);
    localparam logic [PTR_BITS-1:0] HOP_PTR   = PTR_BITS'(HOP);
    localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(FRAME_LEN - 1);

    win_seq_state_t        state, next_state;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   base_ptr;
    logic [PTR_BITS:0]     fill_cnt;
    logic [IDX_BITS-1:0]   rd_idx;
    logic [15:0]           frame_cnt;
    logic                  overrun;
    logic [RD_LATENCY-1:0] valid_pipe;
    logic [RD_LATENCY-1:0] last_pipe;

    logic                  wr_accept;
    logic                  wr_drop;
    logic                  rd_en;
    logic                  retire;
    logic [PTR_BITS-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign wr_accept = bus.audio_valid_in && (fill_cnt < BUF_FULL);
    assign wr_drop   = bus.audio_valid_in && !wr_accept;
    assign rd_addr   = base_ptr + PTR_BITS'(rd_idx);

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        retire     = 1'b0;
        case (state)
            FILL: begin
                if (fill_cnt >= FRAME_CNT) begin
                    next_state = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (bus.frame_ready_in) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                // frame_ready_in is deliberately ignored here: a started frame always completes.
                rd_en = 1'b1;
                if (rd_idx == LAST_IDX) begin
                    next_state = RETIRE;
                end
            end
            RETIRE: begin
                retire     = 1'b1;
                next_state = FILL;
            end
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr    <= '0;
            base_ptr  <= '0;
            fill_cnt  <= '0;
            rd_idx    <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Write and retire may coincide; fill_cnt nets both in one update.
            fill_cnt <= fill_cnt + {{PTR_BITS{1'b0}}, wr_accept} - (retire ? HOP_CNT : '0);
            if (retire) begin
                base_ptr  <= base_ptr + HOP_PTR;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (state == WAIT_RDY) begin
                rd_idx <= '0;
            end else if (rd_en) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (wr_drop) begin
                overrun <= 1'b1;
            end
        end
    end

    // valid/last travel alongside the RAM read so they line up with rd_data and the ROM output.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            valid_pipe[0] <= rd_en;
            last_pipe[0]  <= rd_en && (rd_idx == LAST_IDX);
            for (int k = 1; k < RD_LATENCY; k++) begin
                valid_pipe[k] <= valid_pipe[k-1];
                last_pipe[k]  <= last_pipe[k-1];
            end
        end
    end

    frame_sample_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_LEN),
        .RD_LATENCY (RD_LATENCY)
    ) u_buffer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (bus.audio_sample_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign bus.coeff_addr_out = rd_en ? rd_idx : '0;
    assign bus.sample_out     = rd_data;
    assign bus.win_valid_out  = valid_pipe[RD_LATENCY-1];
    assign bus.win_last_out   = last_pipe[RD_LATENCY-1];
    assign busy_out           = (state == STREAM);
    assign frame_count_out    = frame_cnt;
    assign overrun_out        = overrun;
    assign state_dbg_out      = state;
endmodule

// File: tb/tb_window_frame_sequencer.sv
// Directed bench for window_frame_sequencer with FRAME_LEN=16, HOP=8, RD_LATENCY=2.
// A ROM stand-in whose data equals its address checks coefficient/sample alignment.
module tb_window_frame_sequencer;
    import window_pkg::*;

    localparam int DW = 8;
    localparam int FL = 16;
    localparam int HP = 8;
    localparam int RL = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    window_frame_sequencer_if #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) bus ();
    logic           busy_out;
    logic [15:0]    frame_count_out;
    logic           overrun_out;
    win_seq_state_t state_dbg_out;

    window_frame_sequencer #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL),
        .HOP        (HP),
        .RD_LATENCY (RL)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .bus             (bus),
        .busy_out        (busy_out),
        .frame_count_out (frame_count_out),
        .overrun_out     (overrun_out),
        .state_dbg_out   (state_dbg_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0]  rom1, rom2;
    logic [12:0] cap_q[$];
    logic [12:0] exp_q[$];
    int          cyc_q[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rom1 <= '0;
            rom2 <= '0;
        end else begin
            rom1 <= bus.coeff_addr_out;
            rom2 <= rom1;
        end
    end

    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && bus.win_valid_out === 1'b1) begin
            cap_q.push_back({bus.win_last_out, rom2, bus.sample_out});
            cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic push(input int v);
        bus.audio_sample_in = 8'(v);
        bus.audio_valid_in  = 1'b1;
        @(posedge clk_in);
        #1;
        bus.audio_valid_in  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_in             = 1'b0;
        bus.audio_valid_in = 1'b0;
        bus.frame_ready_in = 1'b0;
        idle(2);
        rst_in = 1'b1;
    endtask

    task automatic clear_q();
        cap_q.delete();
        exp_q.delete();
        cyc_q.delete();
    endtask

    task automatic build_frame(input int first);
        for (int j = 0; j < FL; j++) begin
            exp_q.push_back({(j == FL - 1), 4'(j), 8'(first + j)});
        end
    endtask

    task automatic wait_count(input logic [15:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk_in);
            if (frame_count_out === target) begin
                ok = 1'b1;
                break;
            end
        end
        idle(2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++;
        if ({bus.win_valid_out, bus.win_last_out, busy_out, overrun_out} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.win_valid_out, bus.win_last_out, busy_out, overrun_out});
        end
        checks++;
        if (bus.sample_out !== 8'sd0 || bus.coeff_addr_out !== 4'd0 || frame_count_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: got sample=%0d coeff=%0d count=%0d expected 0 0 0",
                     bus.sample_out, bus.coeff_addr_out, frame_count_out);
        end
        checks++;
        if (state_dbg_out !== FILL) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg_out, FILL);
        end
        idle(2);
        rst_in = 1'b1;
    endtask

    task automatic test_first_frame();
        bit ok;
        clear_q();
        bus.frame_ready_in = 1'b1;
        for (int k = 0; k < 16; k++) push(k);
        wait_count(16'd1, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL first_timeout: got count=%0d expected 1", frame_count_out); end
        build_frame(0);
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL first_len: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL first[%0d]: got {last,coeff,sample}=%h expected %h", k, cap_q[k], exp_q[k]);
            end
        end
        for (int k = 1; k < cyc_q.size(); k++) begin
            checks++;
            if (cyc_q[k] != cyc_q[k-1] + 1) begin
                errors++;
                $display("FAIL first_contig[%0d]: got cycle %0d expected %0d", k, cyc_q[k], cyc_q[k-1] + 1);
            end
        end
    endtask

    task automatic test_overlap();
        bit ok;
        clear_q();
        for (int k = 16; k < 23; k++) push(k);
        idle(10);
        checks++;
        if (cap_q.size() != 0 || frame_count_out !== 16'd1) begin
            errors++;
            $display("FAIL overlap_early: got %0d samples count=%0d expected 0 samples count=1",
                     cap_q.size(), frame_count_out);
        end
        push(23);
        wait_count(16'd2, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL overlap_timeout: got count=%0d expected 2", frame_count_out); end
        build_frame(8);
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL overlap_len: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL overlap[%0d]: got %h expected %h", k, cap_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_wait_ready();
        bit ok;
        int first_n;
        clear_q();
        bus.frame_ready_in = 1'b0;
        for (int k = 24; k < 32; k++) push(k);
        idle(6);
        checks++;
        if (state_dbg_out !== WAIT_RDY || busy_out !== 1'b0 || cap_q.size() != 0) begin
            errors++;
            $display("FAIL wait_hold: got state=%0d busy=%b samples=%0d expected state=%0d busy=0 samples=0",
                     state_dbg_out, busy_out, cap_q.size(), WAIT_RDY);
        end
        bus.frame_ready_in = 1'b1;
        first_n = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_in);
            if (bus.win_valid_out === 1'b1) begin
                first_n = n;
                break;
            end
        end
        checks++;
        if (first_n != 3) begin
            errors++;
            $display("FAIL wait_latency: got %0d cycles expected 3", first_n);
        end
        wait_count(16'd3, 200, ok);
        bus.frame_ready_in = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_timeout: got count=%0d expected 3", frame_count_out); end
        build_frame(16);
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL wait_len: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL wait[%0d]: got %h expected %h", k, cap_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_write_during_stream();
        bit ok;
        clear_q();
        for (int k = 32; k < 40; k++) push(k);
        idle(3);
        bus.frame_ready_in = 1'b1;
        idle(1);
        checks++;
        if (busy_out !== 1'b1) begin errors++; $display("FAIL wds_busy: got %b expected 1", busy_out); end
        for (int k = 0; k < 8; k++) begin
            push(40 + k);
            idle(1);
        end
        bus.frame_ready_in = 1'b0;
        wait_count(16'd4, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wds_timeout: got count=%0d expected 4", frame_count_out); end
        checks++;
        if (dut.fill_cnt !== 6'd16 || state_dbg_out !== WAIT_RDY) begin
            errors++;
            $display("FAIL wds_fill: got fill=%0d state=%0d expected fill=16 state=%0d",
                     dut.fill_cnt, state_dbg_out, WAIT_RDY);
        end
        build_frame(24);
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL wds_len: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL wds[%0d]: got %h expected %h", k, cap_q[k], exp_q[k]);
            end
        end
        clear_q();
        bus.frame_ready_in = 1'b1;
        wait_count(16'd5, 200, ok);
        bus.frame_ready_in = 1'b0;
        checks++;
        if (!ok || dut.fill_cnt !== 6'd8) begin
            errors++;
            $display("FAIL wds_next: got count=%0d fill=%0d expected count=5 fill=8", frame_count_out, dut.fill_cnt);
        end
        build_frame(32);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= cap_q.size() || cap_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL wds_next[%0d]: got %h expected %h", k,
                         (k < cap_q.size()) ? cap_q[k] : 13'h1fff, exp_q[k]);
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        apply_reset();
        clear_q();
        for (int k = 0; k < 32; k++) push(100 + k);
        checks++;
        if (overrun_out !== 1'b0 || dut.fill_cnt !== 6'd32) begin
            errors++;
            $display("FAIL ovr_full: got overrun=%b fill=%0d expected overrun=0 fill=32", overrun_out, dut.fill_cnt);
        end
        push(132);
        idle(3);
        checks++;
        if (overrun_out !== 1'b1 || dut.fill_cnt !== 6'd32) begin
            errors++;
            $display("FAIL ovr_drop: got overrun=%b fill=%0d expected overrun=1 fill=32", overrun_out, dut.fill_cnt);
        end
        bus.frame_ready_in = 1'b1;
        wait_count(16'd3, 600, ok);
        checks++;
        if (!ok || overrun_out !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got count=%0d overrun=%b expected count=3 overrun=1", frame_count_out, overrun_out);
        end
        build_frame(100);
        build_frame(108);
        build_frame(116);
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ovr_len: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL ovr[%0d]: got %h expected %h", k, cap_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        bit found;
        clear_q();
        for (int k = 0; k < 8; k++) push(140 + k);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_in);
            if (busy_out === 1'b1 && bus.coeff_addr_out === 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_find: got no read at index 5 expected one"); end
        rst_in = 1'b0;
        #1;
        checks++;
        if ({bus.win_valid_out, bus.win_last_out, busy_out, overrun_out} !== 4'b0 ||
            bus.sample_out !== 8'sd0 || bus.coeff_addr_out !== 4'd0 || frame_count_out !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: got flags=%b sample=%0d coeff=%0d count=%0d expected all 0",
                     {bus.win_valid_out, bus.win_last_out, busy_out, overrun_out},
                     bus.sample_out, bus.coeff_addr_out, frame_count_out);
        end
        idle(2);
        rst_in = 1'b1;
        clear_q();
        for (int k = 0; k < 15; k++) push(50 + k);
        idle(10);
        checks++;
        if (cap_q.size() != 0 || state_dbg_out !== FILL) begin
            errors++;
            $display("FAIL mid_refill: got samples=%0d state=%0d expected samples=0 state=%0d",
                     cap_q.size(), state_dbg_out, FILL);
        end
        push(65);
        wait_count(16'd1, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_timeout: got count=%0d expected 1", frame_count_out); end
        build_frame(50);
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mid_len: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL mid[%0d]: got %h expected %h", k, cap_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        bus.audio_sample_in = '0;
        bus.audio_valid_in  = 1'b0;
        bus.frame_ready_in  = 1'b0;
        test_reset();
        test_first_frame();
        test_overlap();
        test_wait_ready();
        test_write_during_stream();
        test_overrun();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
